mole_anim_scheduler: RTL and testbench
======================================

Name: mole_anim_scheduler

Overview:
- Sequences per-hole mole pop-up animation for the whack-a-mole display.
- Accepts spawn requests from game logic and hit events from the input decoder.
- Runs one rise/hold/fall FSM per hole, paced by a shared frame tick.
- Drives the occupancy map and per-hole sprite frame indices consumed by the display top.

Parameters:
N_HOLES, 9, number of holes (bit i of map = hole i)
TICK_DIV, 3125000, clk cycles per animation frame step
FRAMES, 16, top sprite frame index (fully up); 0 = empty hole
HOLD_TICKS, 16, ticks a mole stays fully up before retracting
FW, 5, frame index width (must hold FRAMES)

Ports:
clk  in  1  system clock (100 MHz)
rst_n  in  1  asynchronous active-low reset
enable  in  1  high while game state is GAME
spawn_valid  in  1  spawn request
spawn_hole  in  4  hole index for spawn
spawn_ready  out  1  spawn accepted this cycle when valid&ready
hit_valid  in  1  single-cycle hit strobe
hit_hole  in  4  hole index struck
hit_ack  out  1  pulse: hit landed on a rising/held mole
hit_nack  out  1  pulse: hit on empty/falling/invalid hole
miss_mask  out  N_HOLES  per-hole pulse: mole retracted unhit
map  out  N_HOLES  bit i high when hole i state != IDLE
frame_flat  out  N_HOLES*FW  hole i frame at [i*FW +: FW]

Behaviour:
- Reset (async, rst_n low): all holes IDLE, frames 0, hold counters 0, tick counter 0; map, frame_flat, hit_ack, hit_nack, miss_mask = 0.
- Tick counter:
  - Counts 0..TICK_DIV-1 while enable=1; tick=1 on the cycle it equals TICK_DIV-1, then wraps to 0.
  - Held at 0 while enable=0.
- Per-hole FSM, states IDLE, RISE, HOLD, FALL:
  - IDLE: frame 0. Spawn accept -> RISE with frame=1 next cycle, hit flag cleared.
  - RISE: on tick, frame+1. When frame==FRAMES on a tick -> HOLD, hold_cnt=0.
  - HOLD: frame=FRAMES. On tick, hold_cnt+1. When hold_cnt==HOLD_TICKS-1 on a tick -> FALL.
  - FALL: on tick, frame-1. On the tick where frame is 1 -> IDLE with frame 0. If hit flag is clear, miss_mask[i]=1 for exactly that one cycle.
- spawn_ready (combinational):
  - Asserted when enable=1, spawn_hole<N_HOLES, and that hole is IDLE.
  - Requests with ready=0 are dropped, not queued.
- Hits:
  - Evaluated in the cycle hit_valid=1.
  - Target hole in RISE or HOLD: hole -> FALL next cycle keeping its current frame, hit flag set, hit_ack=1 next cycle.
  - Otherwise (IDLE, FALL, hit_hole>=N_HOLES, or enable=0): hit_nack=1 next cycle.
  - hit_ack and hit_nack are never both 1 in the same cycle.
- Simultaneous events:
  - Spawn and hit on the same IDLE hole in one cycle: spawn accepted, hit nacked.
  - Hit and tick in the same cycle on a RISE/HOLD hole: the hit wins, state -> FALL with no frame change that cycle.
- enable deasserted:
  - All holes forced to IDLE next cycle, frames 0.
  - No miss pulses, pending hit nacked.
- Output timing: all outputs registered except spawn_ready. map and frame_flat reflect state with 1-cycle latency from the causing event.
- Width rules: frame arithmetic in FW bits, never under/overflows (bounded by FSM). Tick counter width = clog2(TICK_DIV).

Decomposition:
- Shared package (game pkg): hole-state enum (IDLE/RISE/HOLD/FALL), N_HOLES, FW, default TICK_DIV/FRAMES/HOLD_TICKS constants, also used by the display top.
- One natural sub-module, mole_hole_fsm: single-hole FSM with frame/hold counters.
  - Inputs: tick, start, hit, enable.
  - Outputs: state, frame, miss pulse, hit_ok.
  - Instantiated N_HOLES times by generate.
  - Top owns the tick counter, decode of spawn_hole/hit_hole, and ack/nack registers.

Test Plan (TICK_DIV=4, FRAMES=4, HOLD_TICKS=2):
- Reset: rst_n low mid-animation -> map=0, frame_flat=0, all pulses 0 immediately; after release, spawn_ready=1 for hole 3 with enable=1.
- Full cycle: spawn hole 2 -> frame sequence 1,2,3,4 over 3 ticks, 4 held 2 ticks, then 3,2,1,0. miss_mask=9'b000000100 for one cycle at return to 0; map[2] high throughout.
- Hit on rise: spawn hole 5, hit hole 5 at frame 2 -> hit_ack pulse next cycle, frames 2,1,0, no miss_mask pulse.
- Nacks: hit hole 0 while IDLE -> hit_nack. Hit hole 9 -> hit_nack. Spawn hole 9 -> spawn_ready=0.
- Collision: spawn and hit hole 4 in the same cycle -> spawn accepted (frame 1), hit_nack=1. Second spawn to hole 4 while it is active -> spawn_ready=0.
- Disable: moles active in holes 1 and 7, enable drops -> map=0, frames 0 next cycle, miss_mask stays 0, tick counter reads 0.

Source files
------------

// File: rtl/mole_anim_scheduler_pkg.sv
// Shared whack-a-mole animation types and default sizing, also used by the display top.
package mole_anim_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RISE = 2'd1,
    HOLD = 2'd2,
    FALL = 2'd3
  } hole_state_e;

  localparam int NUM_HOLES      = 9;
  localparam int FRAME_W        = 5;
  localparam int DEF_TICK_DIV   = 3125000;
  localparam int DEF_FRAMES     = 16;
  localparam int DEF_HOLD_TICKS = 16;

endpackage

// File: rtl/mole_hole_fsm.sv
// Single-hole rise/hold/fall sequencer with its own frame index and hold counter.
module mole_hole_fsm
  import mole_anim_scheduler_pkg::*;
#(
  parameter int FRAMES     = DEF_FRAMES,
  parameter int HOLD_TICKS = DEF_HOLD_TICKS,
  parameter int FW         = FRAME_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick_i,
  input  logic          start_i,
  input  logic          hit_i,
  input  logic          enable_i,
  output hole_state_e   state_o,
  output logic [FW-1:0] frame_o,
  output logic          miss_o,
  output logic          hit_ok_o
);

  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  hole_state_e   state_q, state_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          struck_q, struck_d;
  logic          miss_q, miss_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      frame_q  <= '0;
      hold_q   <= '0;
      struck_q <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      hold_q   <= hold_d;
      struck_q <= struck_d;
      miss_q   <= miss_d;
    end
  end

  // A hit always beats a coincident tick: the mole starts falling from where it is.
  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    hold_d   = hold_q;
    struck_d = struck_q;
    miss_d   = 1'b0;
    if (!enable_i) begin
      state_d  = IDLE;
      frame_d  = '0;
      hold_d   = '0;
      struck_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d  = RISE;
            frame_d  = FW'(1);
            struck_d = 1'b0;
          end
        end
        RISE: begin
          if (hit_i) begin
            state_d  = FALL;
            struck_d = 1'b1;
          end else if (tick_i) begin
            if (frame_q == FW'(FRAMES)) begin
              state_d = HOLD;
              hold_d  = '0;
            end else begin
              frame_d = frame_q + FW'(1);
            end
          end
        end
        HOLD: begin
          if (hit_i) begin
            state_d  = FALL;
            struck_d = 1'b1;
          end else if (tick_i) begin
            if (hold_q == HW'(HOLD_TICKS - 1)) begin
              state_d = FALL;
            end else begin
              hold_d = hold_q + HW'(1);
            end
          end
        end
        FALL: begin
          if (tick_i) begin
            if (frame_q == FW'(1)) begin
              state_d = IDLE;
              frame_d = '0;
              miss_d  = !struck_q;
            end else begin
              frame_d = frame_q - FW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    state_o  = state_q;
    frame_o  = frame_q;
    miss_o   = miss_q;
    hit_ok_o = enable_i && hit_i && ((state_q == RISE) || (state_q == HOLD));
  end

endmodule

// File: rtl/mole_anim_scheduler.sv
// Whack-a-mole animation scheduler: frame tick, spawn/hit decode, one FSM per hole.
module mole_anim_scheduler
  import mole_anim_scheduler_pkg::*;
#(
  parameter int N_HOLES    = NUM_HOLES,
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int FRAMES     = DEF_FRAMES,
  parameter int HOLD_TICKS = DEF_HOLD_TICKS,
  parameter int FW         = FRAME_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  spawn_valid,
  input  logic [3:0]            spawn_hole,
  output logic                  spawn_ready,
  input  logic                  hit_valid,
  input  logic [3:0]            hit_hole,
  output logic                  hit_ack,
  output logic                  hit_nack,
  output logic [N_HOLES-1:0]    miss_mask,
  output logic [N_HOLES-1:0]    map,
  output logic [N_HOLES*FW-1:0] frame_flat
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
  logic               tick;
  logic [N_HOLES-1:0] idle_vec, start_vec, hit_vec, hit_ok_vec, miss_vec;
  logic               spawn_idle;
  logic               hit_ack_q, hit_ack_d, hit_nack_q, hit_nack_d;

  always_comb begin
    tick       = enable && (tick_cnt_q == TW'(TICK_DIV - 1));
    tick_cnt_d = (!enable || tick) ? '0 : tick_cnt_q + TW'(1);
  end

  // Out-of-range hole indices match no hole, so they are never ready and always nacked.
  always_comb begin
    spawn_idle = 1'b0;
    start_vec  = '0;
    hit_vec    = '0;
    for (int i = 0; i < N_HOLES; i++) begin
      if (spawn_hole == 4'(i)) spawn_idle = idle_vec[i];
    end
    spawn_ready = enable && spawn_idle;
    for (int i = 0; i < N_HOLES; i++) begin
      start_vec[i] = spawn_valid && spawn_ready && (spawn_hole == 4'(i));
      hit_vec[i]   = hit_valid && enable && (hit_hole == 4'(i));
    end
  end

  always_comb begin
    hit_ack_d  = |hit_ok_vec;
    hit_nack_d = hit_valid && !(|hit_ok_vec);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
      hit_ack_q  <= 1'b0;
      hit_nack_q <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      hit_ack_q  <= hit_ack_d;
      hit_nack_q <= hit_nack_d;
    end
  end

  for (genvar g = 0; g < N_HOLES; g++) begin : g_hole
    hole_state_e   st;
    logic [FW-1:0] fr;

    mole_hole_fsm #(
      .FRAMES     (FRAMES),
      .HOLD_TICKS (HOLD_TICKS),
      .FW         (FW)
    ) u_fsm (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick_i   (tick),
      .start_i  (start_vec[g]),
      .hit_i    (hit_vec[g]),
      .enable_i (enable),
      .state_o  (st),
      .frame_o  (fr),
      .miss_o   (miss_vec[g]),
      .hit_ok_o (hit_ok_vec[g])
    );

    assign idle_vec[g]            = (st == IDLE);
    assign frame_flat[g*FW +: FW] = fr;
  end

  assign map       = ~idle_vec;
  assign miss_mask = miss_vec;
  assign hit_ack   = hit_ack_q;
  assign hit_nack  = hit_nack_q;

endmodule

// File: tb/tb_mole_anim_scheduler.sv
// Directed and random stimulus for mole_anim_scheduler against a per-mole lifetime model.
module tb_mole_anim_scheduler;

  localparam int NH   = 9;
  localparam int TD   = 4;
  localparam int FR   = 4;
  localparam int HT   = 2;
  localparam int W    = 5;
  localparam int LIFE = 2 * FR + HT;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            enable = 1'b0;
  logic            spawn_valid = 1'b0;
  logic [3:0]      spawn_hole = '0;
  logic            hit_valid = 1'b0;
  logic [3:0]      hit_hole = '0;
  logic            spawn_ready, hit_ack, hit_nack;
  logic [NH-1:0]   miss_mask, map;
  logic [NH*W-1:0] frame_flat;

  always #5 clk = ~clk;

  mole_anim_scheduler #(
    .N_HOLES    (NH),
    .TICK_DIV   (TD),
    .FRAMES     (FR),
    .HOLD_TICKS (HT),
    .FW         (W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .spawn_valid (spawn_valid),
    .spawn_hole  (spawn_hole),
    .spawn_ready (spawn_ready),
    .hit_valid   (hit_valid),
    .hit_hole    (hit_hole),
    .hit_ack     (hit_ack),
    .hit_nack    (hit_nack),
    .miss_mask   (miss_mask),
    .map         (map),
    .frame_flat  (frame_flat)
  );

  // Each mole is tracked by ticks elapsed since its spawn; an unstruck mole's frame is a fixed
  // function of that age, a struck one simply counts down from where it was hit.
  int              age [NH];
  bit              struck [NH];
  int              mFrame [NH];
  int              tickPhase;
  logic [NH-1:0]   expMap, expMiss;
  logic [NH*W-1:0] expFrames;
  logic            expAck, expNack;
  int              errors = 0;
  int              checks = 0;

  function automatic int profileFrame(input int k);
    if (k < FR) return k + 1;
    if (k <= FR + HT) return FR;
    return FR - (k - FR - HT);
  endfunction

  function automatic bit holeIdle(input int h);
    if (h >= NH) return 1'b0;
    return age[h] < 0;
  endfunction

  task automatic buildExpected();
    for (int i = 0; i < NH; i++) begin
      expMap[i]           = (age[i] >= 0);
      expFrames[i*W +: W] = W'(mFrame[i]);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NH; i++) begin
      age[i]    = -1;
      struck[i] = 1'b0;
      mFrame[i] = 0;
    end
    tickPhase = 0;
    expMiss   = '0;
    expAck    = 1'b0;
    expNack   = 1'b0;
    buildExpected();
  endtask

  task automatic modelStep(input bit en, input bit sv, input int sh, input bit hv, input int hh);
    bit tick, accept, ok;
    expMiss = '0;
    if (!en) begin
      tickPhase = 0;
      for (int i = 0; i < NH; i++) begin
        age[i]    = -1;
        struck[i] = 1'b0;
        mFrame[i] = 0;
      end
      expAck  = 1'b0;
      expNack = hv;
    end else begin
      tick      = (tickPhase == TD - 1);
      tickPhase = tick ? 0 : tickPhase + 1;
      accept    = sv && holeIdle(sh);
      ok        = hv && (hh < NH) && !holeIdle(hh) && !struck[hh] && (age[hh] < FR + HT);
      for (int i = 0; i < NH; i++) begin
        if (age[i] < 0) begin
          if (accept && sh == i) begin
            age[i]    = 0;
            struck[i] = 1'b0;
            mFrame[i] = 1;
          end
        end else if (ok && hh == i) begin
          struck[i] = 1'b1;
        end else if (tick) begin
          if (struck[i]) begin
            mFrame[i]--;
            if (mFrame[i] == 0) age[i] = -1;
          end else begin
            age[i]++;
            mFrame[i] = profileFrame(age[i]);
            if (age[i] == LIFE) begin
              age[i]     = -1;
              expMiss[i] = 1'b1;
            end
          end
        end
      end
      expAck  = ok;
      expNack = hv && !ok;
    end
    buildExpected();
  endtask

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkVal("map", 64'(map), 64'(expMap));
    checkVal("frame_flat", 64'(frame_flat), 64'(expFrames));
    checkVal("miss_mask", 64'(miss_mask), 64'(expMiss));
    checkVal("hit_ack", 64'(hit_ack), 64'(expAck));
    checkVal("hit_nack", 64'(hit_nack), 64'(expNack));
  endtask

  // One clock of stimulus: ready is checked before the edge, registered outputs just after it.
  task automatic applyStimulus(input bit en, input bit sv, input int sh, input bit hv, input int hh);
    @(negedge clk);
    enable      = en;
    spawn_valid = sv;
    spawn_hole  = 4'(sh);
    hit_valid   = hv;
    hit_hole    = 4'(hh);
    #1;
    checkVal("spawn_ready", 64'(spawn_ready), 64'(en && holeIdle(sh)));
    @(posedge clk);
    modelStep(en, sv, sh, hv, hh);
    #1;
    checkOutput();
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b1, 1'b0, 0, 1'b0, 0);
  endtask

  initial begin
    modelReset();
    #12;
    checkOutput();
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] full rise/hold/fall on hole 2");
    applyStimulus(1'b1, 1'b1, 2, 1'b0, 0);
    idleCycles(46);

    $display("[TB] hit on rising mole in hole 5");
    applyStimulus(1'b1, 1'b1, 5, 1'b0, 0);
    for (int n = 0; n < 20 && mFrame[5] != 2; n++) applyStimulus(1'b1, 1'b0, 0, 1'b0, 0);
    applyStimulus(1'b1, 1'b0, 0, 1'b1, 5);
    idleCycles(12);

    $display("[TB] nacks and out-of-range requests");
    applyStimulus(1'b1, 1'b0, 0, 1'b1, 0);
    applyStimulus(1'b1, 1'b0, 0, 1'b1, 9);
    applyStimulus(1'b1, 1'b1, 9, 1'b0, 0);
    applyStimulus(1'b1, 1'b1, 15, 1'b1, 15);

    $display("[TB] spawn/hit collision on hole 4");
    applyStimulus(1'b1, 1'b1, 4, 1'b1, 4);
    applyStimulus(1'b1, 1'b1, 4, 1'b0, 0);
    idleCycles(6);
    applyStimulus(1'b1, 1'b0, 0, 1'b1, 4);
    idleCycles(3);
    applyStimulus(1'b1, 1'b0, 0, 1'b1, 4);

    $display("[TB] disable with holes 1 and 7 active");
    applyStimulus(1'b1, 1'b1, 1, 1'b0, 0);
    applyStimulus(1'b1, 1'b1, 7, 1'b0, 0);
    idleCycles(9);
    applyStimulus(1'b0, 1'b0, 0, 1'b1, 1);
    applyStimulus(1'b0, 1'b1, 3, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, 0, 1'b0, 0);
    applyStimulus(1'b1, 1'b1, 1, 1'b0, 0);
    idleCycles(10);

    $display("[TB] asynchronous reset mid-animation");
    applyStimulus(1'b1, 1'b1, 6, 1'b0, 0);
    idleCycles(6);
    @(negedge clk);
    enable      = 1'b0;
    spawn_valid = 1'b0;
    hit_valid   = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 3, 1'b0, 0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 600; n++) begin
      applyStimulus(($urandom_range(0, 39) != 0),
                    ($urandom_range(0, 1) == 1),
                    int'($urandom_range(0, 10)),
                    ($urandom_range(0, 3) == 0),
                    int'($urandom_range(0, 10)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
